// File: rtl/limb_arith_pkg.sv
// Shared constants and types for the limb-arithmetic datapath
// (shift-add multiplier and serial restoring divider).
package limb_arith_pkg;

   localparam int N_BITS_DEF = 258;
   localparam int D_BITS_DEF = 130;

   localparam int MUL_A_BITS = 130;
   localparam int MUL_B_BITS = 128;
   localparam int MUL_P_BITS = 258;

   localparam int CNT_BITS = $clog2(N_BITS_DEF + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ZDIV = 2'd2
   } div_state_t;

   // 2^130 - 5
   localparam logic [129:0] POLY1305_P = {130{1'b1}} - 130'd4;

endpackage

// File: rtl/serial_divider_258x130_divu_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor when it fits.
module divu_step #(
   parameter int D_BITS = 130
) (
   input  logic [D_BITS-1:0] r_in,
   input  logic              bit_in,
   input  logic [D_BITS-1:0] d_in,
   output logic [D_BITS-1:0] r_out,
   output logic              q_bit
);

   logic [D_BITS:0] t;

   always_comb begin
      t = {r_in, bit_in};
      if (t >= {1'b0, d_in}) begin
         // R < D before the shift, so the difference always fits in D_BITS
         r_out = D_BITS'(t - {1'b0, d_in});
         q_bit = 1'b1;
      end else begin
         r_out = t[D_BITS-1:0];
         q_bit = 1'b0;
      end
   end

endmodule

// File: rtl/serial_divider_258x130.sv
// Serial restoring divider: one quotient bit per cycle, start/busy/done
// handshake shared with the shift-add multiplier.
module serial_divider_258x130
   import limb_arith_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF,
   parameter int D_BITS = D_BITS_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [N_BITS-1:0] dividend_in,
   input  logic [D_BITS-1:0] divisor_in,
   output logic [N_BITS-1:0] quotient_out,
   output logic [D_BITS-1:0] remainder_out,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero
);

   localparam int CW = $clog2(N_BITS + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(N_BITS - 1);

   div_state_t        state_q, state_d;
   logic [N_BITS-1:0] q_q, q_d;
   logic [D_BITS-1:0] d_q, d_d;
   // The partial remainder's extra top bit only exists inside the step compare
   logic [D_BITS-1:0] r_q, r_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N_BITS-1:0] quot_q, quot_d;
   logic [D_BITS-1:0] rem_q, rem_d;
   logic              dbz_q, dbz_d;
   logic              done_q, done_d;

   logic [D_BITS-1:0] step_r;
   logic              step_qbit;
   logic [N_BITS-1:0] q_shift;

   divu_step #(
      .D_BITS(D_BITS)
   ) u_step (
      .r_in  (r_q),
      .bit_in(q_q[N_BITS-1]),
      .d_in  (d_q),
      .r_out (step_r),
      .q_bit (step_qbit)
   );

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      d_d     = d_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      q_shift = {q_q[N_BITS-2:0], step_qbit};

      case (state_q)
         IDLE: begin
            if (start) begin
               q_d     = dividend_in;
               d_d     = divisor_in;
               r_d     = '0;
               cnt_d   = '0;
               state_d = (divisor_in == '0) ? ZDIV : RUN;
            end
         end
         RUN: begin
            q_d   = q_shift;
            r_d   = step_r;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               quot_d  = q_shift;
               rem_d   = step_r;
               dbz_d   = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         ZDIV: begin
            // Remainder reports the captured dividend, not the live input
            quot_d  = '1;
            rem_d   = q_q[D_BITS-1:0];
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         d_q     <= d_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign quotient_out  = quot_q;
   assign remainder_out = rem_q;
   assign div_by_zero   = dbz_q;
   assign done          = done_q;
   assign busy          = (state_q == RUN);

endmodule

// File: tb/tb_serial_divider_258x130.sv
// Scoreboard bench for serial_divider_258x130: directed vectors push
// expected results, a monitor checks each done pulse.
module tb_serial_divider_258x130;
   import limb_arith_pkg::*;

   localparam int N = 258;
   localparam int D = 130;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [N-1:0] dividend_in;
   logic [D-1:0] divisor_in;
   logic [N-1:0] quotient_out;
   logic [D-1:0] remainder_out;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   serial_divider_258x130 dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .dividend_in  (dividend_in),
      .divisor_in   (divisor_in),
      .quotient_out (quotient_out),
      .remainder_out(remainder_out),
      .busy         (busy),
      .done         (done),
      .div_by_zero  (div_by_zero)
   );

   typedef struct {
      logic [N-1:0] q;
      logic [D-1:0] r;
      logic         dbz;
      int           lat;
      int           busy_cycles;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   busy_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: one line per completed transaction
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            busy_cnt = 0;
         end else if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("quotient", quotient_out, e.q);
               chk("remainder", N'(remainder_out), N'(e.r));
               chk("div_by_zero", N'(div_by_zero), N'(e.dbz));
               chk("latency", N'(cyc - e.acc), N'(e.lat));
               chk("busy_cycles", N'(busy_cnt), N'(e.busy_cycles));
               $display("txn done cycle=%0d q=%h r=%h dbz=%0d busy_cycles=%0d",
                        cyc, quotient_out, remainder_out, div_by_zero, busy_cnt);
            end
            busy_cnt = 0;
         end else if (busy) begin
            busy_cnt++;
         end
      end
   end

   // Drive one request; inputs are scrambled right after acceptance to
   // show they are captured. Pushes the expected result.
   task automatic issue(input logic [N-1:0] a, input logic [D-1:0] b,
                        input logic [N-1:0] eq, input logic [D-1:0] er,
                        input logic edbz);
      exp_t e;
      @(negedge clk);
      dividend_in = a;
      divisor_in  = b;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      dividend_in = ~a;
      divisor_in  = ~b;
      e.q = eq;
      e.r = er;
      e.dbz = edbz;
      e.lat = edbz ? 1 : N;
      e.busy_cycles = edbz ? 0 : N;
      e.acc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done required=done");
      end
   endtask

   task automatic run_div(input logic [N-1:0] a, input logic [D-1:0] b,
                          input logic [N-1:0] eq, input logic [D-1:0] er,
                          input logic edbz);
      issue(a, b, eq, er, edbz);
      wait_done();
   endtask

   initial begin
      logic [N-1:0] ones;
      logic [N-1:0] big;
      logic [D-1:0] pw;
      logic [159:0] ra;
      logic [127:0] rb;

      reset_n = 1'b0;
      start = 1'b0;
      dividend_in = '0;
      divisor_in = '0;
      ones = '1;

      repeat (3) @(negedge clk);
      chk("reset_quotient", quotient_out, '0);
      chk("reset_remainder", N'(remainder_out), '0);
      chk("reset_busy", N'(busy), '0);
      chk("reset_done", N'(done), '0);
      chk("reset_dbz", N'(div_by_zero), '0);
      reset_n = 1'b1;

      run_div(N'(100), D'(7), N'(14), D'(2), 1'b0);

      big = N'(5) * N'(POLY1305_P) + N'(3);
      run_div(big, POLY1305_P, N'(5), D'(3), 1'b0);

      run_div(ones, D'(1), ones, '0, 1'b0);
      pw = D'(1) << 129;
      run_div(ones, pw, (N'(1) << 129) - N'(1), pw - D'(1), 1'b0);

      run_div(N'(16'h1234), '0, ones, D'(16'h1234), 1'b1);

      // Second start mid-run must be ignored
      issue(N'(1000), D'(3), N'(333), D'(1), 1'b0);
      repeat (49) @(negedge clk);
      dividend_in = N'(999);
      divisor_in  = D'(5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Reset 100 cycles into a run: aborts with no done
      @(negedge clk);
      dividend_in = N'(2000);
      divisor_in  = D'(7);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort_quotient", quotient_out, '0);
      chk("abort_remainder", N'(remainder_out), '0);
      chk("abort_dbz", N'(div_by_zero), '0);
      chk("abort_busy", N'(busy), '0);
      chk("abort_done", N'(done), '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("abort_no_done_busy", N'(busy), '0);

      run_div(N'(12345), D'(100), N'(123), D'(45), 1'b0);

      // Round trip: (a*b)/b = a, remainder 0
      for (int k = 0; k < 12; k++) begin
         ra = {$urandom, $urandom, $urandom, $urandom, $urandom};
         rb = {$urandom, $urandom, $urandom, $urandom};
         if (rb == '0) rb = 128'd1;
         run_div(N'(ra[129:0]) * N'(rb), D'(rb), N'(ra[129:0]), '0, 1'b0);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", N'(exp_q.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
